// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl_pkg
// Purpose  : Shared codes for the shift-register sequencer: SRwPR mode select
//            values, direction codes, FSM state encoding, mode helper.
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_ctrl_pkg;

    // SRwPR.S mode select codes
    localparam logic [1:0] c_SR_HOLD = 2'b00;
    localparam logic [1:0] c_SR_SHR  = 2'b01;
    localparam logic [1:0] c_SR_SHL  = 2'b10;
    localparam logic [1:0] c_SR_LOAD = 2'b11;

    // Command direction codes
    localparam logic c_DIR_RIGHT = 1'b0;
    localparam logic c_DIR_LEFT  = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Map a command direction onto the SRwPR shift mode
    function automatic logic [1:0] shift_mode(input logic dir);
        return (dir == c_DIR_LEFT) ? c_SR_SHL : c_SR_SHR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl_cnt
// Purpose  : Loadable saturating down-counter holding the remaining number of
//            shift cycles. Decrement stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Sequencer for an 8-bit shift register with parallel load (SRwPR).
//            Accepts a command, issues one load then N shift cycles, streams
//            the outgoing bit on ser_out and returns the final contents.
// Options  : SHIFT_SEQ_ROTATE_EN - adds cmd_rot; when set the shifted-out bit
//            is fed back as the fill bit instead of ser_in.
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             cmd_rot,
`endif
    input  logic             ser_in,
    output logic             ser_out,
    output logic [1:0]       sr_S,
    output logic [WIDTH-1:0] sr_In,
    output logic             sr_sl,
    output logic             sr_sr,
    input  logic [WIDTH-1:0] sr_Y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_eff;
    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_last;

    assign w_accept  = cmd_valid && cmd_ready;
    // More shifts than register bits would only refill it; clamp to WIDTH
    assign w_cnt_eff = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;
    assign w_last    = (w_count == CNT_W'(1)) || w_zero;

    shift_seq_ctrl_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (w_cnt_eff),
        .i_dec      (r_state == ST_SHIFT),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // State register; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command fields captured at the accept handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_dir  <= c_DIR_RIGHT;
        end else if (w_accept) begin
            r_data <= cmd_data;
            r_dir  <= cmd_dir;
        end
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    logic r_rot;

    // Rotate flag travels with the command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot <= 1'b0;
        end else if (w_accept) begin
            r_rot <= cmd_rot;
        end
    end

    assign sr_sl = r_rot ? sr_Y[WIDTH-1] : ser_in;
    assign sr_sr = r_rot ? sr_Y[0]       : ser_in;
`else
    assign sr_sl = ser_in;
    assign sr_sr = ser_in;
`endif

    // The register holds its value in RESP, so its output is the result
    assign rsp_data = sr_Y;

    // Next state and outputs; everything is forced quiet while rst is high
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        sr_S      = c_SR_HOLD;
        sr_In     = '0;
        rsp_valid = 1'b0;
        ser_out   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (w_accept) begin
                        w_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sr_S   = c_SR_LOAD;
                    sr_In  = r_data;
                    w_next = w_zero ? ST_RESP : ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_S    = shift_mode(r_dir);
                    ser_out = (r_dir == c_DIR_LEFT) ? sr_Y[WIDTH-1] : sr_Y[0];
                    if (w_last) begin
                        w_next = ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        w_next = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
